// File: rtl/el2_pkg.sv
// el2_pkg: shared types and constants for the debug-trigger CSR bank.
//   el2_trigger_pkt_t : per-trigger packet consumed by the LSU trigger matcher
//   el2_mcontrol_t    : stored (writable) fields of one mcontrol tdata1
//   CSR_* / MC_*      : CSR addresses and mcontrol bit positions
//   mcontrol_rd()     : builds the 32-bit tdata1 readback word
package el2_pkg;

   typedef struct packed {
      logic        select;
      logic        match;
      logic        store;
      logic        load;
      logic        execute;
      logic        m;
      logic [31:0] tdata2;
   } el2_trigger_pkt_t;

   localparam logic [11:0] CSR_TSELECT = 12'h7A0;
   localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
   localparam logic [11:0] CSR_TDATA2  = 12'h7A2;

   localparam int unsigned MC_TYPE_LSB    = 28;
   localparam int unsigned MC_DMODE       = 27;
   localparam int unsigned MC_MASKMAX_LSB = 21;
   localparam int unsigned MC_HIT         = 20;
   localparam int unsigned MC_SELECT      = 19;
   localparam int unsigned MC_ACTION      = 12;
   localparam int unsigned MC_ACTION_MSB  = 15;
   localparam int unsigned MC_CHAIN       = 11;
   localparam int unsigned MC_MATCH       = 7;
   localparam int unsigned MC_M           = 6;
   localparam int unsigned MC_EXECUTE     = 2;
   localparam int unsigned MC_STORE       = 1;
   localparam int unsigned MC_LOAD        = 0;

   localparam logic [3:0] MC_TYPE    = 4'd2;
   localparam logic [5:0] MC_MASKMAX = 6'd31;

   typedef struct packed {
      logic dmode;
      logic hit;
      logic select;
      logic action;
      logic chain;
      logic match;
      logic m;
      logic execute;
      logic store;
      logic load;
   } el2_mcontrol_t;

   function automatic logic [31:0] mcontrol_rd(input el2_mcontrol_t mc);
      logic [31:0] rd;
      rd                                   = '0;
      rd[MC_TYPE_LSB+3:MC_TYPE_LSB]        = MC_TYPE;
      rd[MC_MASKMAX_LSB+5:MC_MASKMAX_LSB]  = MC_MASKMAX;
      rd[MC_DMODE]                         = mc.dmode;
      rd[MC_HIT]                           = mc.hit;
      rd[MC_SELECT]                        = mc.select;
      rd[MC_ACTION]                        = mc.action;
      rd[MC_CHAIN]                         = mc.chain;
      rd[MC_MATCH]                         = mc.match;
      rd[MC_M]                             = mc.m;
      rd[MC_EXECUTE]                       = mc.execute;
      rd[MC_STORE]                         = mc.store;
      rd[MC_LOAD]                          = mc.load;
      return rd;
   endfunction

endpackage

// File: rtl/el2_trigger_csr_entry.sv
// el2_trigger_csr_entry: one mcontrol trigger's tdata1/tdata2 registers.
//   clk, rst_l      : clock, synchronous active-low reset
//   dbg_mode        : core in debug mode (gates dmode writes / protection)
//   wr_tdata1/2     : write strobes already decoded for this trigger
//   wdata           : CSR write data
//   partner_dmode   : dmode of the chaining partner trigger
//   hit_set         : qualified hit on this trigger this cycle
//   mc              : stored mcontrol fields
//   enabled         : trigger armed (m and at least one access type)
//   pkt             : packet for the LSU trigger matcher
//   tdata1_rd       : tdata1 readback word
//   tdata2          : stored tdata2
module el2_trigger_csr_entry
   import el2_pkg::*;
#(
   parameter bit CHAIN_CAPABLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             dbg_mode,
   input  logic             wr_tdata1,
   input  logic             wr_tdata2,
   input  logic [31:0]      wdata,
   input  logic             partner_dmode,
   input  logic             hit_set,
   output el2_mcontrol_t    mc,
   output logic             enabled,
   output el2_trigger_pkt_t pkt,
   output logic [31:0]      tdata1_rd,
   output logic [31:0]      tdata2
);

   logic          wr_ok;
   el2_mcontrol_t mc_wr;

   // A debug-owned trigger is read-only to machine-mode code.
   assign wr_ok = ~(mc.dmode & ~dbg_mode);

   always_comb begin
      mc_wr         = '0;
      mc_wr.dmode   = wdata[MC_DMODE] & dbg_mode;
      mc_wr.hit     = wdata[MC_HIT];
      mc_wr.select  = wdata[MC_SELECT];
      // Only actions 0 and 1 are supported; anything larger falls back to 0.
      mc_wr.action  = (wdata[MC_ACTION_MSB:MC_ACTION] == 4'd1);
      // A chain may not span triggers owned by different modes.
      mc_wr.chain   = CHAIN_CAPABLE & wdata[MC_CHAIN] & (partner_dmode == mc_wr.dmode);
      mc_wr.match   = wdata[MC_MATCH];
      mc_wr.m       = wdata[MC_M];
      mc_wr.execute = wdata[MC_EXECUTE];
      mc_wr.store   = wdata[MC_STORE];
      mc_wr.load    = wdata[MC_LOAD];
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         mc     <= '0;
         tdata2 <= '0;
      end else begin
         // A tdata1 write overrides a same-cycle hit, including the hit bit.
         if (wr_tdata1 && wr_ok) begin
            mc <= mc_wr;
         end else if (hit_set) begin
            mc.hit <= 1'b1;
         end
         if (wr_tdata2 && wr_ok) begin
            tdata2 <= wdata;
         end
      end
   end

   assign enabled = mc.m & (mc.execute | mc.store | mc.load);

   always_comb begin
      pkt         = '0;
      pkt.select  = mc.select;
      pkt.match   = mc.match;
      pkt.store   = mc.store;
      pkt.load    = mc.load;
      pkt.execute = mc.execute;
      pkt.m       = mc.m;
      pkt.tdata2  = tdata2;
   end

   assign tdata1_rd = mcontrol_rd(mc);

endmodule

// File: rtl/el2_dec_trigger_csr.sv
// el2_dec_trigger_csr: debug-trigger CSR bank and R-stage hit reporting.
//   clk, rst_l            : clock, synchronous active-low reset
//   csr_wr_en/addr/wdata  : CSR write port (tselect/tdata1/tdata2)
//   csr_rdata             : combinational readback of the addressed CSR
//   dbg_mode, mstatus_mie : hit inhibit qualifiers
//   lsu_valid_m           : LSU access valid in M
//   lsu_trigger_match_m   : raw per-trigger match from the LSU
//   kill_r                : R-stage flush
//   trigger_pkt_any       : per-trigger packets to the LSU matcher
//   trigger_hit_r         : qualified hits in R
//   trigger_bkpt_r        : breakpoint request (action 0)
//   trigger_halt_r        : debug-halt request (action 1)
module el2_dec_trigger_csr
   import el2_pkg::*;
#(
   parameter int unsigned NTRIG = 4
) (
   input  logic                         clk,
   input  logic                         rst_l,
   input  logic                         csr_wr_en,
   input  logic [11:0]                  csr_addr,
   input  logic [31:0]                  csr_wdata,
   output logic [31:0]                  csr_rdata,
   input  logic                         dbg_mode,
   input  logic                         mstatus_mie,
   input  logic                         lsu_valid_m,
   input  logic [NTRIG-1:0]             lsu_trigger_match_m,
   input  logic                         kill_r,
   output el2_trigger_pkt_t [NTRIG-1:0] trigger_pkt_any,
   output logic [NTRIG-1:0]             trigger_hit_r,
   output logic                         trigger_bkpt_r,
   output logic                         trigger_halt_r
);

   logic [1:0]       tselect;
   logic [NTRIG-1:0] match_r;
   logic [NTRIG-1:0] enabled;
   logic [NTRIG-1:0] action;
   logic [NTRIG-1:0] q;
   logic [NTRIG-1:0] wr_tdata1;
   logic [NTRIG-1:0] wr_tdata2;
   el2_mcontrol_t    mc        [NTRIG];
   logic [31:0]      tdata1_rd [NTRIG];
   logic [31:0]      tdata2    [NTRIG];

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         tselect <= '0;
      end else if (csr_wr_en && (csr_addr == CSR_TSELECT)) begin
         tselect <= csr_wdata[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         match_r <= '0;
      end else begin
         match_r <= lsu_trigger_match_m & {NTRIG{lsu_valid_m}} & enabled;
      end
   end

   for (genvar gi = 0; gi < NTRIG; gi++) begin : g_entry
      assign wr_tdata1[gi] = csr_wr_en & (csr_addr == CSR_TDATA1) & (tselect == 2'(gi));
      assign wr_tdata2[gi] = csr_wr_en & (csr_addr == CSR_TDATA2) & (tselect == 2'(gi));
      assign action[gi]    = mc[gi].action;

      el2_trigger_csr_entry #(
         .CHAIN_CAPABLE((gi % 2) == 0)
      ) u_entry (
         .clk           (clk),
         .rst_l         (rst_l),
         .dbg_mode      (dbg_mode),
         .wr_tdata1     (wr_tdata1[gi]),
         .wr_tdata2     (wr_tdata2[gi]),
         .wdata         (csr_wdata),
         .partner_dmode (mc[gi ^ 1].dmode),
         .hit_set       (trigger_hit_r[gi]),
         .mc            (mc[gi]),
         .enabled       (enabled[gi]),
         .pkt           (trigger_pkt_any[gi]),
         .tdata1_rd     (tdata1_rd[gi]),
         .tdata2        (tdata2[gi])
      );
   end

   // Chained pair (even, odd) only fires when both halves matched.
   for (genvar gp = 0; gp < NTRIG / 2; gp++) begin : g_chain
      logic both;
      assign both          = match_r[2*gp] & match_r[2*gp+1];
      assign q[2*gp]       = mc[2*gp].chain ? both : match_r[2*gp];
      assign q[2*gp+1]     = mc[2*gp].chain ? both : match_r[2*gp+1];
   end

   assign trigger_hit_r  = q & {NTRIG{~(dbg_mode | kill_r)}} & (action | {NTRIG{mstatus_mie}});
   assign trigger_bkpt_r = |(trigger_hit_r & ~action);
   assign trigger_halt_r = |(trigger_hit_r & action);

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         CSR_TSELECT: csr_rdata = {30'd0, tselect};
         CSR_TDATA1:  csr_rdata = tdata1_rd[tselect];
         CSR_TDATA2:  csr_rdata = tdata2[tselect];
         default:     csr_rdata = '0;
      endcase
   end

endmodule
